// File: rtl/aip_iq_gain_slave.sv
// AIP slave endpoint: buffers packed I/Q words, applies a saturating signed
// Q2.14 gain to each component and returns the results through aip_dataout.
module aip_iq_gain_slave #(
    parameter int          DEPTH = 64,
    parameter logic [31:0] IP_ID = 32'h1A0C_0001
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [4:0]  aip_config,
    input  logic [31:0] aip_datain,
    input  logic        aip_read,
    input  logic        aip_write,
    input  logic        aip_start,
    input  logic        core_int,
    output logic [31:0] aip_dataout,
    output logic        aip_int
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // {saturated, y} for y = sat16((x*g) >>> 14)
    function automatic logic [16:0] sat_mul(input logic [15:0] x, input logic [15:0] g);
        logic signed [31:0] p;
        logic signed [31:0] sh;
        p  = $signed({{16{x[15]}}, x}) * $signed({{16{g[15]}}, g});
        sh = p >>> 14;
        if (sh > 32'sd32767) begin
            sat_mul = {1'b1, 16'h7FFF};
        end else if (sh < -32'sd32768) begin
            sat_mul = {1'b1, 16'h8000};
        end else begin
            sat_mul = {1'b0, sh[15:0]};
        end
    endfunction

    logic [31:0]   r_in_buf  [DEPTH];
    logic [31:0]   r_out_buf [DEPTH];

    state_t        r_state;
    logic [AW:0]   r_len;
    logic [AW:0]   r_idx;
    logic          r_drain;
    logic [15:0]   r_gain;
    logic          r_int_en;
    logic          r_done;
    logic          r_busy;
    logic          r_sat;
    logic          r_err;
    logic [AW-1:0] r_ptr_in;
    logic [AW-1:0] r_ptr_out;
    logic [31:0]   r_dataout;
    logic          r_int;

    logic          r_s1_vld;
    logic [AW-1:0] r_s1_idx;
    logic [31:0]   r_s1_data;
    logic          r_s2_vld;
    logic [AW-1:0] r_s2_idx;
    logic [31:0]   r_s2_data;

    logic          w_wr_status;
    logic          w_clr_status;
    logic          w_wr_prot;
    logic          w_wr_blocked;
    logic          w_wr_ok;
    logic          w_wr_din;
    logic [AW:0]   w_len_wdata;
    logic [31:0]   w_rd_data;
    logic [16:0]   w_y_i;
    logic [16:0]   w_y_q;

    assign w_wr_status  = aip_write && (aip_config == 5'h01);
    assign w_clr_status = w_wr_status && aip_datain[0];
    assign w_wr_prot    = aip_write && (aip_config >= 5'h02) && (aip_config <= 5'h05);
    assign w_wr_blocked = w_wr_prot && r_busy;
    assign w_wr_ok      = aip_write && !r_busy;
    assign w_wr_din     = w_wr_ok && (aip_config == 5'h05);
    assign w_len_wdata  = (aip_datain > 32'(DEPTH)) ? LEN_MAX : aip_datain[AW:0];

    assign w_y_i = sat_mul(r_s1_data[31:16], r_gain);
    assign w_y_q = sat_mul(r_s1_data[15:0],  r_gain);

    assign aip_dataout = r_dataout;
    assign aip_int     = r_int;

    // Register-map read mux; values are pre-write for a same-cycle write.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        case (aip_config)
            5'h00:   w_rd_data = IP_ID;
            5'h01:   w_rd_data = {27'b0, r_err, r_sat, r_int_en, r_busy, r_done};
            5'h02:   w_rd_data = 32'(r_len);
            5'h03:   w_rd_data = {16'h0000, r_gain};
            5'h04:   w_rd_data = 32'({r_ptr_out, r_ptr_in});
            5'h06:   w_rd_data = r_out_buf[r_ptr_out];
            default: w_rd_data = 32'h0000_0000;
        endcase
    end

    // Bus-side configuration registers, pointers, read data and interrupt.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_dataout <= 32'h0000_0000;
            r_int     <= 1'b0;
            r_len     <= '0;
            r_gain    <= 16'h4000;
            r_int_en  <= 1'b0;
            r_err     <= 1'b0;
            r_ptr_in  <= '0;
            r_ptr_out <= '0;
        end else begin
            if (aip_read) begin
                r_dataout <= w_rd_data;
                if (aip_config == 5'h06) begin
                    r_ptr_out <= r_ptr_out + PTR_ONE;
                end
            end
            if (w_wr_status) begin
                r_int_en <= aip_datain[2];
                if (aip_datain[0]) begin
                    r_err <= 1'b0;
                end
            end
            if (w_wr_blocked) begin
                r_err <= 1'b1;
            end
            if (w_wr_ok) begin
                case (aip_config)
                    5'h02: r_len  <= w_len_wdata;
                    5'h03: r_gain <= aip_datain[15:0];
                    5'h04: begin
                        r_ptr_in  <= aip_datain[AW-1:0];
                        r_ptr_out <= aip_datain[AW-1:0];
                    end
                    5'h05: r_ptr_in <= r_ptr_in + PTR_ONE;
                    default: ;
                endcase
            end
            r_int <= r_done & r_int_en;
        end
    end

    // Sequencer: walks indices 0..LEN-1, flushes the two-stage pipeline, raises done.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_drain   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sat     <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_idx  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_idx  <= '0;
            r_s2_data <= 32'h0000_0000;
        end else begin
            if (w_clr_status) begin
                r_done <= 1'b0;
                r_sat  <= 1'b0;
            end
            if (r_s1_vld && (w_y_i[16] || w_y_q[16])) begin
                r_sat <= 1'b1;
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_idx  <= r_s1_idx;
            r_s2_data <= {w_y_i[15:0], w_y_q[15:0]};
            r_s1_vld  <= 1'b0;
            r_s1_idx  <= r_idx[AW-1:0];
            case (r_state)
                ST_IDLE: begin
                    if (aip_start) begin
                        if (r_len != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_idx   <= '0;
                            r_done  <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (core_int) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_s2_vld <= 1'b0;
                    end else begin
                        r_s1_vld <= 1'b1;
                        if (r_idx == r_len - LEN_ONE) begin
                            r_state <= ST_DRAIN;
                            r_drain <= 1'b0;
                        end else begin
                            r_idx <= r_idx + LEN_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (core_int) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_s2_vld <= 1'b0;
                    end else if (r_drain) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Input buffer: bus write port and pipeline stage-1 read port.
    always_ff @(posedge clk_clk) begin
        if (w_wr_din) begin
            r_in_buf[r_ptr_in] <= aip_datain;
        end
        r_s1_data <= r_in_buf[r_idx[AW-1:0]];
    end

    // Output buffer: written from pipeline stage 2.
    always_ff @(posedge clk_clk) begin
        if (r_s2_vld) begin
            r_out_buf[r_s2_idx] <= r_s2_data;
        end
    end

endmodule
